wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback-select logic for the 5-stage MIPS core.
- Captures memory-stage results on each clock.
- Performs load-data extraction/extension and selects the writeback source.
- Drives the register file write port (address, data, PC for trace) and the WB-stage forwarding bus.

---
 rtl/wb_stage_if.sv | 30 +++
 rtl/wb_stage.sv | 105 ++++++++++
 tb/tb_wb_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM->WB bundle: memory-stage results and pipeline controls in, then register
// file write port and WB forwarding bus out.
interface wb_stage_if;
  logic        stall;
  logic        flush;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [4:0]  m_rd;
  logic [1:0]  m_wsel;
  logic [31:0] m_alu;
  logic [31:0] m_mem;
  logic [2:0]  m_ltype;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic        w_valid;
  logic [4:0]  w_fwd_addr;
  logic [31:0] w_fwd_data;

  // The pipeline control drives the stage inputs and observes the writeback.
  modport master (
    output stall, flush, m_valid, m_pc, m_rd, m_wsel, m_alu, m_mem, m_ltype,
    input  grf_a3, grf_wd, grf_pc, w_valid, w_fwd_addr, w_fwd_data
  );

  modport slave (
    input  stall, flush, m_valid, m_pc, m_rd, m_wsel, m_alu, m_mem, m_ltype,
    output grf_a3, grf_wd, grf_pc, w_valid, w_fwd_addr, w_fwd_data
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with writeback-source select for the 5-stage MIPS core.
// Sub-word load extraction (lb/lbu/lh/lhu) is built only when WB_LOAD_EXT_EN is defined.
module wb_stage #(
  parameter logic [31:0] LINK_OFFSET = 32'd8
) (
  input  logic       clk,
  input  logic       reset,
  wb_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    WSEL_ALU  = 2'b00,
    WSEL_MEM  = 2'b01,
    WSEL_LINK = 2'b10,
    WSEL_NONE = 2'b11
  } wsel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    wsel_e       wsel;
    logic [31:0] alu;
    logic [31:0] mem;
`ifdef WB_LOAD_EXT_EN
    logic [2:0]  ltype;
`endif
  } stage_t;

  stage_t d, q;
  logic [31:0] load_data;
  logic [31:0] wd;

  always_comb begin
    d.valid = bus.m_valid;
    d.pc    = bus.m_pc;
    d.rd    = bus.m_rd;
    d.wsel  = wsel_e'(bus.m_wsel);
    d.alu   = bus.m_alu;
    d.mem   = bus.m_mem;
`ifdef WB_LOAD_EXT_EN
    d.ltype = bus.m_ltype;
`endif
  end

  // A flushed stage is indistinguishable from a freshly reset one.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset || bus.flush) q <= '0;
    else if (!bus.stall)    q <= d;
  end

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    ld_byte = q.mem[7:0];
    case (q.alu[1:0])
      2'd1:    ld_byte = q.mem[15:8];
      2'd2:    ld_byte = q.mem[23:16];
      2'd3:    ld_byte = q.mem[31:24];
      default: ld_byte = q.mem[7:0];
    endcase
    // Halfword loads ignore alu[0]; misalignment is not trapped here.
    ld_half = q.alu[1] ? q.mem[31:16] : q.mem[15:0];
    case (q.ltype)
      3'b001:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  load_data = {24'd0, ld_byte};
      3'b011:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {16'd0, ld_half};
      default: load_data = q.mem;
    endcase
  end
`else
  // Word loads only; the load-type port stays on the bundle but has no effect.
  logic unused_ltype;
  assign unused_ltype = ^bus.m_ltype;
  assign load_data    = q.mem;
`endif

  always_comb begin
    wd = '0;
    if (q.valid) begin
      case (q.wsel)
        WSEL_ALU:  wd = q.alu;
        WSEL_MEM:  wd = load_data;
        WSEL_LINK: wd = q.pc + LINK_OFFSET;
        default:   wd = '0;
      endcase
    end
  end

  // The register file writes on any nonzero address, so no-write cases present 0.
  assign bus.grf_a3     = (q.valid && q.wsel != WSEL_NONE) ? q.rd : 5'd0;
  assign bus.grf_wd     = wd;
  assign bus.grf_pc     = q.valid ? q.pc : 32'd0;
  assign bus.w_valid    = q.valid;
  assign bus.w_fwd_addr = bus.grf_a3;
  assign bus.w_fwd_data = wd;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: the driver queues expected writeback per cycle,
// a monitor pops and compares one cycle later, after the capturing edge.
module tb_wb_stage;

`ifdef WB_LOAD_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif
  localparam logic [31:0] MEMW = 32'h80FF7F01;

  typedef struct {
    string       name;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  wb_stage_if bus ();

  wb_stage #(.LINK_OFFSET(32'd8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge and queue what WB must show
  // after the next rising edge.
  task automatic cyc(input string nm, input logic rst, input logic st, input logic fl,
                     input logic v, input logic [31:0] pc, input logic [4:0] rd,
                     input logic [1:0] ws, input logic [31:0] alu, input logic [31:0] mem,
                     input logic [2:0] lt, input logic [4:0] ea3, input logic [31:0] ewd,
                     input logic [31:0] epc, input logic ev);
    exp_t e;
    @(negedge clk);
    reset       = rst;
    bus.stall   = st;
    bus.flush   = fl;
    bus.m_valid = v;
    bus.m_pc    = pc;
    bus.m_rd    = rd;
    bus.m_wsel  = ws;
    bus.m_alu   = alu;
    bus.m_mem   = mem;
    bus.m_ltype = lt;
    e.name = nm; e.a3 = ea3; e.wd = ewd; e.pc = epc; e.v = ev;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".a3"},    {27'd0, bus.grf_a3},     {27'd0, e.a3});
        check({e.name, ".wd"},    bus.grf_wd,              e.wd);
        check({e.name, ".pc"},    bus.grf_pc,              e.pc);
        check({e.name, ".valid"}, {31'd0, bus.w_valid},    {31'd0, e.v});
        check({e.name, ".fa"},    {27'd0, bus.w_fwd_addr}, {27'd0, e.a3});
        check({e.name, ".fd"},    bus.w_fwd_data,          e.wd);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "time limit");
  end

  initial begin : stim
    bus.stall = 0; bus.flush = 0; bus.m_valid = 0; bus.m_pc = 0; bus.m_rd = 0;
    bus.m_wsel = 0; bus.m_alu = 0; bus.m_mem = 0; bus.m_ltype = 0;

    // Reset (with garbage on the inputs), then idle.
    cyc("rst0", 1, 0, 0, 1, 32'h1234, 5'd3, 2'b00, 32'hDEAD, 0, 0,  0, 0, 0, 0);
    cyc("rst1", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0,                   0, 0, 0, 0);
    cyc("idle0", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0,                  0, 0, 0, 0);
    cyc("idle1", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0,                  0, 0, 0, 0);

    // ALU and link writebacks, including PC wrap.
    cyc("alu",   0, 0, 0, 1, 32'h3000, 5'd5, 2'b00, 32'h12345678, 0, 0,
        5'd5, 32'h12345678, 32'h3000, 1);
    cyc("link",  0, 0, 0, 1, 32'h3004, 5'd31, 2'b10, 32'h0, 0, 0,
        5'd31, 32'h300C, 32'h3004, 1);
    cyc("linkw", 0, 0, 0, 1, 32'hFFFFFFFC, 5'd31, 2'b10, 32'h0, 0, 0,
        5'd31, 32'h4, 32'hFFFFFFFC, 1);

    // Loads from word 0x80FF7F01.
    cyc("lb3",  0, 0, 0, 1, 32'h100, 5'd8, 2'b01, 32'h1003, MEMW, 3'b001,
        5'd8, EXT ? 32'hFFFFFF80 : MEMW, 32'h100, 1);
    cyc("lbu2", 0, 0, 0, 1, 32'h104, 5'd8, 2'b01, 32'h1002, MEMW, 3'b010,
        5'd8, EXT ? 32'h000000FF : MEMW, 32'h104, 1);
    cyc("lh2",  0, 0, 0, 1, 32'h108, 5'd8, 2'b01, 32'h1002, MEMW, 3'b011,
        5'd8, EXT ? 32'hFFFF80FF : MEMW, 32'h108, 1);
    cyc("lhu0", 0, 0, 0, 1, 32'h10C, 5'd8, 2'b01, 32'h1000, MEMW, 3'b100,
        5'd8, EXT ? 32'h00007F01 : MEMW, 32'h10C, 1);
    cyc("lw",   0, 0, 0, 1, 32'h110, 5'd8, 2'b01, 32'h1000, MEMW, 3'b000,
        5'd8, MEMW, 32'h110, 1);
    cyc("lb0",  0, 0, 0, 1, 32'h114, 5'd8, 2'b01, 32'h1000, MEMW, 3'b001,
        5'd8, EXT ? 32'h00000001 : MEMW, 32'h114, 1);
    cyc("lh1",  0, 0, 0, 1, 32'h118, 5'd8, 2'b01, 32'h1001, MEMW, 3'b011,
        5'd8, EXT ? 32'h00007F01 : MEMW, 32'h118, 1);
    cyc("lt5",  0, 0, 0, 1, 32'h11C, 5'd8, 2'b01, 32'h1003, MEMW, 3'b101,
        5'd8, MEMW, 32'h11C, 1);

    // Stall holds across changing inputs; flush beats stall.
    cyc("ld9",  0, 0, 0, 1, 32'h200, 5'd9, 2'b00, 32'hA, 0, 0,      5'd9, 32'hA, 32'h200, 1);
    cyc("stl0", 0, 1, 0, 1, 32'h204, 5'd4, 2'b10, 32'hB, 0, 0,      5'd9, 32'hA, 32'h200, 1);
    cyc("stl1", 0, 1, 0, 1, 32'h208, 5'd6, 2'b00, 32'hC, 0, 0,      5'd9, 32'hA, 32'h200, 1);
    cyc("stl2", 0, 1, 0, 0, 32'h20C, 5'd7, 2'b01, 32'hD, MEMW, 1,   5'd9, 32'hA, 32'h200, 1);
    cyc("flst", 0, 1, 1, 1, 32'h210, 5'd2, 2'b00, 32'hE, 0, 0,      0, 0, 0, 0);

    // No-write cases.
    cyc("rd0",  0, 0, 0, 1, 32'h300, 5'd0, 2'b00, 32'h55, 0, 0,     0, 32'h55, 32'h300, 1);
    cyc("none", 0, 0, 0, 1, 32'h304, 5'd7, 2'b11, 32'h66, 0, 0,     0, 0, 32'h304, 1);
    cyc("inv",  0, 0, 0, 0, 32'h308, 5'd7, 2'b00, 32'h77, 0, 0,     0, 0, 0, 0);

    // Plain flush, then reset during a stall.
    cyc("ld4",  0, 0, 0, 1, 32'h400, 5'd4, 2'b00, 32'h44, 0, 0,     5'd4, 32'h44, 32'h400, 1);
    cyc("fl",   0, 0, 1, 1, 32'h404, 5'd5, 2'b00, 32'h45, 0, 0,     0, 0, 0, 0);
    cyc("ld3",  0, 0, 0, 1, 32'h500, 5'd3, 2'b00, 32'h33, 0, 0,     5'd3, 32'h33, 32'h500, 1);
    cyc("stl3", 0, 1, 0, 1, 32'h504, 5'd1, 2'b00, 32'h34, 0, 0,     5'd3, 32'h33, 32'h500, 1);
    cyc("rstl", 1, 1, 0, 1, 32'h508, 5'd1, 2'b00, 32'h35, 0, 0,     0, 0, 0, 0);
    cyc("post", 0, 0, 0, 1, 32'h50C, 5'd2, 2'b10, 32'h0, 0, 0,      5'd2, 32'h514, 32'h50C, 1);

    @(negedge clk);
    @(negedge clk);
    check("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
